// File: rtl/iq_power_ms.sv
// iq_power_ms: instantaneous I/Q power with millisecond window framing.
//
// Computes I*I + Q*Q through a three-stage pipeline. A free-running window
// counter produces a window-end pulse that is delayed to line up with the
// pipeline output. The block also counts the power samples that land in
// each window.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - asynchronous active-high reset
//   in_valid    - in_i/in_q qualify this cycle
//   in_i, in_q  - signed 16-bit I/Q samples
//   ms_sync     - one-cycle window realignment strobe
//   power       - unsigned I*I+Q*Q of the latest valid sample (held otherwise)
//   power_valid - power updated this cycle
//   ms_out      - one-cycle window-end pulse, pipeline aligned
//   win_samples - power_valid count of the last completed window
module iq_power_ms #(
  parameter int unsigned CLKS_PER_MS = 150000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic signed [15:0] in_i,
  input  logic signed [15:0] in_q,
  input  logic               ms_sync,
  output logic        [31:0] power,
  output logic               power_valid,
  output logic               ms_out,
  output logic        [17:0] win_samples
);

  localparam logic [17:0] TermCnt = 18'(CLKS_PER_MS - 1);
  localparam logic [17:0] SatMax  = '1;

  // Stage 1: input registers
  logic signed [15:0] s1_i_q, s1_q_q;
  logic               s1_v_q;

  // Stage 2: squares, 31 bits each (largest is 2^30 at -32768)
  logic signed [30:0] i_ext, q_ext;
  logic        [30:0] ii_sq, qq_sq;
  logic        [30:0] s2_ii_q, s2_qq_q;
  logic               s2_v_q;

  // Stage 3: sum
  logic        [31:0] power_q;
  logic               pv_q;

  // Window framing
  logic        [17:0] ms_cnt_q, ms_cnt_d;
  logic               tick;
  logic               tick1_q, tick2_q, ms_out_q;

  // Sample counting
  logic        [17:0] smp_cnt_q, smp_cnt_d, smp_inc;
  logic        [17:0] win_q, win_d;

  // Sign-extend before multiplying so the product width is 31 bits throughout.
  assign i_ext = {{15{s1_i_q[15]}}, s1_i_q};
  assign q_ext = {{15{s1_q_q[15]}}, s1_q_q};
  assign ii_sq = $unsigned(i_ext * i_ext);
  assign qq_sq = $unsigned(q_ext * q_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_i_q  <= '0;
      s1_q_q  <= '0;
      s1_v_q  <= 1'b0;
      s2_ii_q <= '0;
      s2_qq_q <= '0;
      s2_v_q  <= 1'b0;
      power_q <= '0;
      pv_q    <= 1'b0;
    end else begin
      s1_i_q  <= in_i;
      s1_q_q  <= in_q;
      s1_v_q  <= in_valid;
      s2_ii_q <= ii_sq;
      s2_qq_q <= qq_sq;
      s2_v_q  <= s1_v_q;
      pv_q    <= s2_v_q;
      if (s2_v_q) begin
        power_q <= {1'b0, s2_ii_q} + {1'b0, s2_qq_q};
      end
    end
  end

  // ms_sync wins over terminal count: it realigns and swallows that tick.
  assign tick = (ms_cnt_q == TermCnt) && !ms_sync;

  always_comb begin
    ms_cnt_d = ms_cnt_q + 18'd1;
    if (ms_sync || (ms_cnt_q == TermCnt)) begin
      ms_cnt_d = '0;
    end
  end

  // A coincident power_valid belongs to the window that is closing.
  always_comb begin
    smp_inc   = (smp_cnt_q == SatMax) ? smp_cnt_q : smp_cnt_q + 18'd1;
    smp_cnt_d = smp_cnt_q;
    win_d     = win_q;
    if (ms_out_q) begin
      win_d     = pv_q ? smp_inc : smp_cnt_q;
      smp_cnt_d = '0;
    end else if (pv_q) begin
      smp_cnt_d = smp_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_cnt_q  <= '0;
      tick1_q   <= 1'b0;
      tick2_q   <= 1'b0;
      ms_out_q  <= 1'b0;
      smp_cnt_q <= '0;
      win_q     <= '0;
    end else begin
      ms_cnt_q  <= ms_cnt_d;
      tick1_q   <= tick;
      tick2_q   <= tick1_q;
      ms_out_q  <= tick2_q;
      smp_cnt_q <= smp_cnt_d;
      win_q     <= win_d;
    end
  end

  assign power       = power_q;
  assign power_valid = pv_q;
  assign ms_out      = ms_out_q;
  assign win_samples = win_q;

endmodule
